// File: rtl/regs_wb_arbiter.sv
// Write-back arbiter and busy-bit scoreboard for the 8x16 register bank.
// ALU and MEM producers share the single bank write port, round-robin on ties.
// Optional macro: REGS_BYPASS_EN (adds forwarding outputs, removes in-flight stall term).
module regs_wb_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned NREGS  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_reg,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_reg,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_reg,
  output logic              issue_ok,
  input  logic [ADDR_W-1:0] rd_reg1,
  input  logic [ADDR_W-1:0] rd_reg2,
  output logic              rd_stall,
`ifdef REGS_BYPASS_EN
  output logic              fwd1_hit,
  output logic              fwd2_hit,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic [NREGS-1:0]  busy_mask,
  output logic              regWrite,
  output logic [ADDR_W-1:0] reg3,
  output logic [DATA_W-1:0] dataToWrite
);

  typedef enum logic {RR_ALU = 1'b0, RR_MEM = 1'b1} rr_e;

  rr_e               r_rr_ptr;
  rr_e               w_rr_next;
  logic              w_tie;
  logic              w_xfer;
  logic [ADDR_W-1:0] w_win_reg;
  logic [DATA_W-1:0] w_win_data;
  logic [NREGS-1:0]  r_busy;
  logic [NREGS-1:0]  w_set;
  logic [NREGS-1:0]  w_clr;
  logic              r_we;
  logic [ADDR_W-1:0] r_reg3;
  logic [DATA_W-1:0] r_data;
  logic              w_inflight;

  // Grant: a lone requester wins; on a tie the round-robin pointer decides.
  assign w_tie     = alu_valid && mem_valid;
  assign alu_ready = !reset && alu_valid && (!mem_valid || (r_rr_ptr == RR_ALU));
  assign mem_ready = !reset && mem_valid && (!alu_valid || (r_rr_ptr == RR_MEM));
  assign w_xfer    = alu_ready || mem_ready;

  // Winner payload mux.
  always_comb begin
    w_win_reg  = mem_reg;
    w_win_data = mem_data;
    if (alu_ready) begin
      w_win_reg  = alu_reg;
      w_win_data = alu_data;
    end
  end

  // Round-robin pointer state register.
  always_ff @(posedge clock) begin
    if (reset) r_rr_ptr <= RR_ALU;
    else       r_rr_ptr <= w_rr_next;
  end

  // Round-robin next state: flips only when both producers compete.
  always_comb begin
    w_rr_next = r_rr_ptr;
    if (w_tie) w_rr_next = (r_rr_ptr == RR_ALU) ? RR_MEM : RR_ALU;
  end

  // Scoreboard set/clear masks; set is applied after clear so it wins.
  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (issue_valid && issue_ok) w_set[issue_reg] = 1'b1;
    if (w_xfer)                  w_clr[w_win_reg] = 1'b1;
  end

  // Busy-bit register.
  always_ff @(posedge clock) begin
    if (reset) r_busy <= '0;
    else       r_busy <= (r_busy & ~w_clr) | w_set;
  end

  // Bank write port register; address/data hold when idle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_we   <= 1'b0;
      r_reg3 <= '0;
      r_data <= '0;
    end else begin
      r_we <= w_xfer;
      if (w_xfer) begin
        r_reg3 <= w_win_reg;
        r_data <= w_win_data;
      end
    end
  end

  assign issue_ok    = !r_busy[issue_reg];
  assign busy_mask   = r_busy;
  assign regWrite    = r_we;
  assign reg3        = r_reg3;
  assign dataToWrite = r_data;

`ifdef REGS_BYPASS_EN
  assign fwd1_hit   = r_we && (r_reg3 == rd_reg1);
  assign fwd2_hit   = r_we && (r_reg3 == rd_reg2);
  assign fwd_data   = r_data;
  assign w_inflight = 1'b0;
`else
  assign w_inflight = r_we && ((r_reg3 == rd_reg1) || (r_reg3 == rd_reg2));
`endif

  assign rd_stall = r_busy[rd_reg1] || r_busy[rd_reg2] || w_inflight;

endmodule
